// File: rtl/ins_cache_sa_if.sv
// Fetch-side and memory-side handshake bundle for the set-associative icache.
// The cache uses the slave view; the fetch unit / memory controller use master.
interface ins_cache_sa_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              en;
  logic              flush_i;
  logic              if_en_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic              if_en_o;
  logic [DATA_W-1:0] if_ins_o;
  logic              mc_en_i;
  logic [DATA_W-1:0] mc_ins_i;
  logic              mc_en_o;
  logic [ADDR_W-1:0] mc_pc_o;
  logic              busy_o;
  logic [CNT_W-1:0]  hit_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  modport slave (
    input  en, flush_i, if_en_i, if_pc_i, mc_en_i, mc_ins_i,
    output if_en_o, if_ins_o, mc_en_o, mc_pc_o, busy_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output en, flush_i, if_en_i, if_pc_i, mc_en_i, mc_ins_i,
    input  if_en_o, if_ins_o, mc_en_o, mc_pc_o, busy_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/ins_cache_sa.sv
// Set-associative instruction cache with true-LRU age counters, one outstanding
// miss, flush, and hit/miss counters.
module ins_cache_sa #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int SET_W  = 2,
  parameter int WAY_W  = 1,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  ins_cache_sa_if.slave bus
);

  localparam int SETS  = 1 << SET_W;
  localparam int WAYS  = 1 << WAY_W;
  localparam int AGE_W = (WAY_W == 0) ? 1 : WAY_W;
  localparam int TAG_W = ADDR_W - SET_W - 2;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [DATA_W-1:0] data_d  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [AGE_W-1:0]  age_d   [SETS][WAYS];
  logic              if_en_q, if_en_d;
  logic [DATA_W-1:0] if_ins_q, if_ins_d;
  logic              mc_en_q, mc_en_d;
  logic [ADDR_W-1:0] mc_pc_q, mc_pc_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [SET_W-1:0]  req_idx, miss_idx, touch_set;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic [AGE_W-1:0]  hit_way, victim, touch_way;
  logic              hit, touch;
  logic              unused_pc_lsbs;

  // mc_pc_q doubles as the latched miss address used by the fill.
  assign req_idx  = bus.if_pc_i[SET_W+1:2];
  assign req_tag  = bus.if_pc_i[ADDR_W-1:SET_W+2];
  assign miss_idx = mc_pc_q[SET_W+1:2];
  assign miss_tag = mc_pc_q[ADDR_W-1:SET_W+2];
  assign unused_pc_lsbs = ^bus.if_pc_i[1:0];

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Oldest way by default; any invalid way (lowest first) overrides it.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[miss_idx][w] == AGE_MAX) victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[miss_idx][w]) victim = AGE_W'(w);
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    age_d      = age_q;
    if_en_d    = 1'b0;
    if_ins_d   = if_ins_q;
    mc_en_d    = 1'b0;
    mc_pc_d    = mc_pc_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    touch      = 1'b0;
    touch_set  = '0;
    touch_way  = '0;
    if (bus.flush_i) begin
      state_d    = S_IDLE;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_d[s][w] = 1'b0;
          age_d[s][w]   = AGE_W'(w);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.if_en_i) begin
            if (hit) begin
              if_en_d   = 1'b1;
              if_ins_d  = data_q[req_idx][hit_way];
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
              touch     = 1'b1;
              touch_set = req_idx;
              touch_way = hit_way;
            end else begin
              mc_en_d    = 1'b1;
              mc_pc_d    = bus.if_pc_i;
              miss_cnt_d = miss_cnt_q + CNT_W'(1);
              state_d    = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.mc_en_i) begin
            valid_d[miss_idx][victim] = 1'b1;
            tag_d[miss_idx][victim]   = miss_tag;
            data_d[miss_idx][victim]  = bus.mc_ins_i;
            if_en_d   = 1'b1;
            if_ins_d  = bus.mc_ins_i;
            touch     = 1'b1;
            touch_set = miss_idx;
            touch_way = victim;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Touched way becomes MRU; only younger ways age, keeping a permutation.
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[touch_set][w] < age_q[touch_set][touch_way])
            age_d[touch_set][w] = age_q[touch_set][w] + AGE_W'(1);
        end
        age_d[touch_set][touch_way] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      if_en_q    <= 1'b0;
      if_ins_q   <= '0;
      mc_en_q    <= 1'b0;
      mc_pc_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else if (bus.en) begin
      state_q    <= state_d;
      if_en_q    <= if_en_d;
      if_ins_q   <= if_ins_d;
      mc_en_q    <= mc_en_d;
      mc_pc_q    <= mc_pc_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign bus.if_en_o    = if_en_q & bus.en;
  assign bus.if_ins_o   = if_ins_q;
  assign bus.mc_en_o    = mc_en_q & bus.en;
  assign bus.mc_pc_o    = mc_pc_q;
  assign bus.busy_o     = (state_q == S_WAIT);
  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_ins_cache_sa.sv
// Directed bench for ins_cache_sa: a 4-set/2-way instance and a 4-set/4-way
// instance share stimulus; the sel field picks which one is observed.
module tb_ins_cache_sa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1, flush = 1'b0, if_en = 1'b0, mc_en = 1'b0;
  logic [16:0] if_pc = '0;
  logic [31:0] mc_ins = '0;
  bit          sel = 1'b0;

  always #5 clk = ~clk;

  ins_cache_sa_if #(.ADDR_W(17), .DATA_W(32), .CNT_W(32)) bA ();
  ins_cache_sa_if #(.ADDR_W(17), .DATA_W(32), .CNT_W(32)) bB ();

  assign bA.en = en;      assign bB.en = en;
  assign bA.flush_i = flush; assign bB.flush_i = flush;
  assign bA.if_en_i = if_en; assign bB.if_en_i = if_en;
  assign bA.if_pc_i = if_pc; assign bB.if_pc_i = if_pc;
  assign bA.mc_en_i = mc_en; assign bB.mc_en_i = mc_en;
  assign bA.mc_ins_i = mc_ins; assign bB.mc_ins_i = mc_ins;

  ins_cache_sa #(.ADDR_W(17), .DATA_W(32), .SET_W(2), .WAY_W(1), .CNT_W(32))
    dut_a (.clk(clk), .rst(rst), .bus(bA));
  ins_cache_sa #(.ADDR_W(17), .DATA_W(32), .SET_W(2), .WAY_W(2), .CNT_W(32))
    dut_b (.clk(clk), .rst(rst), .bus(bB));

  logic        o_if_en, o_mc_en, o_busy;
  logic [31:0] o_ins, o_hit, o_miss;
  logic [16:0] o_pc;
  assign o_if_en = sel ? bB.if_en_o    : bA.if_en_o;
  assign o_mc_en = sel ? bB.mc_en_o    : bA.mc_en_o;
  assign o_busy  = sel ? bB.busy_o     : bA.busy_o;
  assign o_ins   = sel ? bB.if_ins_o   : bA.if_ins_o;
  assign o_pc    = sel ? bB.mc_pc_o    : bA.mc_pc_o;
  assign o_hit   = sel ? bB.hit_cnt_o  : bA.hit_cnt_o;
  assign o_miss  = sel ? bB.miss_cnt_o : bA.miss_cnt_o;

  typedef enum {OP_FETCH, OP_FLUSH, OP_RESET} op_t;
  typedef struct {
    op_t         op;
    bit          sel;
    logic [16:0] pc;
    logic [31:0] fill;      // fill word on a miss, expected word on a hit
    bit          exp_hit;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[24];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(op_t op, bit s, logic [16:0] pc, logic [31:0] fill,
                              bit h, logic [31:0] eh, logic [31:0] em);
    vec_t v;
    v.op = op; v.sel = s; v.pc = pc; v.fill = fill;
    v.exp_hit = h; v.exp_hits = eh; v.exp_misses = em;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    sel = v.sel;
    case (v.op)
      OP_RESET: begin
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_if_en", 64'(o_if_en), 64'd0);
        chk("rst_mc_en", 64'(o_mc_en), 64'd0);
        chk("rst_ins", 64'(o_ins), 64'd0);
        chk("rst_mc_pc", 64'(o_pc), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
      end
      OP_FLUSH: begin
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_if_en", 64'(o_if_en), 64'd0);
        chk("flush_busy", 64'(o_busy), 64'd0);
      end
      default: begin
        if_pc = v.pc; if_en = 1'b1; step(); if_en = 1'b0;
        if (v.exp_hit) begin
          chk("hit_if_en", 64'(o_if_en), 64'd1);
          chk("hit_no_mc_en", 64'(o_mc_en), 64'd0);
          chk("hit_ins", 64'(o_ins), 64'(v.fill));
          chk("hit_busy", 64'(o_busy), 64'd0);
        end else begin
          chk("miss_mc_en", 64'(o_mc_en), 64'd1);
          chk("miss_mc_pc", 64'(o_pc), 64'(v.pc));
          chk("miss_no_if_en", 64'(o_if_en), 64'd0);
          chk("miss_busy", 64'(o_busy), 64'd1);
          step(); step();
          mc_en = 1'b1; mc_ins = v.fill; step(); mc_en = 1'b0;
          chk("fill_if_en", 64'(o_if_en), 64'd1);
          chk("fill_ins", 64'(o_ins), 64'(v.fill));
          chk("fill_busy", 64'(o_busy), 64'd0);
        end
      end
    endcase
    chk("hit_cnt", 64'(o_hit), 64'(v.exp_hits));
    chk("miss_cnt", 64'(o_miss), 64'(v.exp_misses));
  endtask

  task automatic run_table(int first, int last);
    for (int i = first; i <= last; i++) run_vec(vecs[i]);
  endtask

  initial begin
    // 2-way set 0 (index pc[3:2]=0): cold miss, hit, flush, LRU eviction.
    vecs[0]  = mk(OP_RESET, 0, 17'h0,    32'h0,        0, 0, 0);
    vecs[1]  = mk(OP_FETCH, 0, 17'h0010, 32'h00500093, 0, 0, 1);
    vecs[2]  = mk(OP_FETCH, 0, 17'h0010, 32'h00500093, 1, 1, 1);
    vecs[3]  = mk(OP_FLUSH, 0, 17'h0,    32'h0,        0, 0, 0);
    vecs[4]  = mk(OP_FETCH, 0, 17'h0000, 32'hA0000000, 0, 0, 1);
    vecs[5]  = mk(OP_FETCH, 0, 17'h0010, 32'hA1000010, 0, 0, 2);
    vecs[6]  = mk(OP_FETCH, 0, 17'h0020, 32'hA2000020, 0, 0, 3);
    vecs[7]  = mk(OP_FETCH, 0, 17'h0010, 32'hA1000010, 1, 1, 3);
    vecs[8]  = mk(OP_FETCH, 0, 17'h0030, 32'hA3000030, 0, 1, 4);
    vecs[9]  = mk(OP_FETCH, 0, 17'h0020, 32'hC2000020, 0, 1, 5);
    vecs[10] = mk(OP_FETCH, 0, 17'h0000, 32'hC0000000, 0, 1, 6);
    vecs[11] = mk(OP_FETCH, 0, 17'h0020, 32'hC2000020, 1, 2, 6);
    vecs[12] = mk(OP_FETCH, 0, 17'h0000, 32'hC0000000, 1, 3, 6);
    // 4-way instance, set 1: five tags, the first filled is evicted.
    vecs[13] = mk(OP_RESET, 1, 17'h0,    32'h0,        0, 0, 0);
    vecs[14] = mk(OP_FETCH, 1, 17'h0004, 32'hB0000004, 0, 0, 1);
    vecs[15] = mk(OP_FETCH, 1, 17'h0014, 32'hB1000014, 0, 0, 2);
    vecs[16] = mk(OP_FETCH, 1, 17'h0024, 32'hB2000024, 0, 0, 3);
    vecs[17] = mk(OP_FETCH, 1, 17'h0034, 32'hB3000034, 0, 0, 4);
    vecs[18] = mk(OP_FETCH, 1, 17'h0044, 32'hB4000044, 0, 0, 5);
    vecs[19] = mk(OP_FETCH, 1, 17'h0014, 32'hB1000014, 1, 1, 5);
    vecs[20] = mk(OP_FETCH, 1, 17'h0024, 32'hB2000024, 1, 2, 5);
    vecs[21] = mk(OP_FETCH, 1, 17'h0034, 32'hB3000034, 1, 3, 5);
    vecs[22] = mk(OP_FETCH, 1, 17'h0044, 32'hB4000044, 1, 4, 5);
    vecs[23] = mk(OP_FETCH, 1, 17'h0004, 32'hB5000004, 0, 4, 6);

    step();
    run_table(0, 12);

    // Miss address latched; a request during WAIT is ignored.
    if_pc = 17'h0004; if_en = 1'b1; step(); if_en = 1'b0;
    chk("latch_mc_en", 64'(o_mc_en), 64'd1);
    chk("latch_mc_pc", 64'(o_pc), 64'h4);
    if_pc = 17'h0008; if_en = 1'b1; step(); if_en = 1'b0;
    chk("wait_req_no_mc_en", 64'(o_mc_en), 64'd0);
    chk("wait_req_no_if_en", 64'(o_if_en), 64'd0);
    chk("wait_mc_pc_held", 64'(o_pc), 64'h4);
    chk("wait_busy", 64'(o_busy), 64'd1);
    step();
    mc_en = 1'b1; mc_ins = 32'hDEADBEEF; step(); mc_en = 1'b0;
    chk("latch_fill_if_en", 64'(o_if_en), 64'd1);
    chk("latch_fill_ins", 64'(o_ins), 64'hDEADBEEF);
    run_vec(mk(OP_FETCH, 0, 17'h0004, 32'hDEADBEEF, 1, 4, 7));
    run_vec(mk(OP_FETCH, 0, 17'h0008, 32'h12345678, 0, 4, 8));

    // Flush while a miss is outstanding; the late fill is dropped.
    if_pc = 17'h0040; if_en = 1'b1; step(); if_en = 1'b0;
    chk("fm_mc_en", 64'(o_mc_en), 64'd1);
    chk("fm_miss_cnt", 64'(o_miss), 64'd9);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fm_busy", 64'(o_busy), 64'd0);
    chk("fm_hit_cnt", 64'(o_hit), 64'd0);
    chk("fm_miss_cnt0", 64'(o_miss), 64'd0);
    step();
    mc_en = 1'b1; mc_ins = 32'h55555555; step(); mc_en = 1'b0;
    chk("fm_late_fill_dropped", 64'(o_if_en), 64'd0);
    chk("fm_late_busy", 64'(o_busy), 64'd0);
    run_vec(mk(OP_FETCH, 0, 17'h0040, 32'h40404040, 0, 0, 1));

    // Fill and new request in the same WAIT cycle: fill wins.
    if_pc = 17'h0080; if_en = 1'b1; step(); if_en = 1'b0;
    chk("sim_mc_en", 64'(o_mc_en), 64'd1);
    step();
    mc_en = 1'b1; mc_ins = 32'h80808080; if_pc = 17'h0044; if_en = 1'b1;
    step(); mc_en = 1'b0; if_en = 1'b0;
    chk("sim_if_en", 64'(o_if_en), 64'd1);
    chk("sim_ins", 64'(o_ins), 64'h80808080);
    chk("sim_no_mc_en", 64'(o_mc_en), 64'd0);
    step();
    chk("sim_req_ignored", 64'(o_mc_en), 64'd0);
    chk("sim_idle", 64'(o_busy), 64'd0);

    // en=0: pulses lost, nothing changes.
    en = 1'b0;
    if_pc = 17'h0040; if_en = 1'b1; step(); if_en = 1'b0;
    chk("en0_if_en", 64'(o_if_en), 64'd0);
    chk("en0_mc_en", 64'(o_mc_en), 64'd0);
    mc_en = 1'b1; mc_ins = 32'hFFFFFFFF; step(); mc_en = 1'b0;
    en = 1'b1; step();
    chk("en1_if_en", 64'(o_if_en), 64'd0);
    chk("en1_hit_cnt", 64'(o_hit), 64'd0);
    chk("en1_miss_cnt", 64'(o_miss), 64'd2);
    chk("en1_busy", 64'(o_busy), 64'd0);
    run_vec(mk(OP_FETCH, 0, 17'h0040, 32'h40404040, 1, 1, 2));
    run_vec(mk(OP_FETCH, 0, 17'h0044, 32'h44444444, 0, 1, 3));

    // Reset mid-miss abandons it; the late fill is ignored.
    if_pc = 17'h0100; if_en = 1'b1; step(); if_en = 1'b0;
    chk("rm_mc_en", 64'(o_mc_en), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rm_busy", 64'(o_busy), 64'd0);
    chk("rm_mc_pc", 64'(o_pc), 64'd0);
    chk("rm_miss_cnt", 64'(o_miss), 64'd0);
    mc_en = 1'b1; mc_ins = 32'h01010101; step(); mc_en = 1'b0;
    chk("rm_late_fill", 64'(o_if_en), 64'd0);
    run_vec(mk(OP_FETCH, 0, 17'h0040, 32'h40404041, 0, 0, 1));

    run_table(13, 23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ins_cache_sa.md
Name: ins_cache_sa

Overview:
- Parametrised set-associative instruction cache between instruction fetch (IF) and the memory controller (MC).
- Generalises the fixed 4-set/2-way icache with:
  - configurable set count and associativity;
  - true-LRU replacement via per-line age counters;
  - miss-address latching, so the fill goes to the missed PC, not the current one;
  - a flush port that invalidates all lines and cancels an outstanding miss;
  - hit/miss performance counters.
- One read port, one miss outstanding at a time.

Parameters:
ADDR_W, 17, byte-address width of if_pc_i / mc_pc_o
DATA_W, 32, instruction word width
SET_W, 2, log2(number of sets); sets = 2**SET_W
WAY_W, 1, log2(associativity); legal values 0, 1, 2 (1/2/4 ways)
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  global ready; when 0, no state changes and if_en_o/mc_en_o drive 0
flush_i  in  1  invalidate all lines; cancel any pending miss
if_en_i  in  1  fetch request valid (single-cycle pulse)
if_pc_i  in  ADDR_W  fetch byte address, word aligned
if_en_o  out  1  instruction valid, one-cycle pulse
if_ins_o  out  DATA_W  instruction
mc_en_i  in  1  memory fill data valid, one-cycle pulse
mc_ins_i  in  DATA_W  fill instruction
mc_en_o  out  1  miss request, one-cycle pulse
mc_pc_o  out  ADDR_W  miss address
busy_o  out  1  high while a miss is outstanding
hit_cnt_o  out  CNT_W  completed hits since reset/flush
miss_cnt_o  out  CNT_W  issued misses since reset/flush

Behaviour:
- Address split:
  - index = pc[SET_W+1:2]
  - tag = pc[ADDR_W-1:SET_W+2]
  - pc[1:0] ignored
- Each line holds valid, tag, data and age (WAY_W bits).
- Reset: all valid=0; all ages set to the way index.
  - Outputs: if_en_o=0, if_ins_o=0, mc_en_o=0, mc_pc_o=0, busy_o=0, counters=0.
  - FSM goes to IDLE. Reset mid-miss abandons the miss; a late mc_en_i is ignored because the FSM is in IDLE.
- Output pulses: if_en_o and mc_en_o default to 0 every enabled cycle.
- FSM, IDLE:
  - if_en_i and hit in way w:
    - next cycle: if_en_o=1, if_ins_o=data[index][w].
    - w becomes MRU: age=0; ways with age < old age of w increment.
    - hit_cnt +1.
    - Latency 1.
  - if_en_i and miss:
    - next cycle: mc_en_o=1, mc_pc_o=if_pc_i.
    - Latch if_pc_i into miss_pc; miss_cnt +1; go to WAIT; busy_o=1.
  - Multiple hitting ways (cannot occur): lowest way wins.
- FSM, WAIT:
  - if_en_i is ignored; IF must not issue until if_en_o.
  - On mc_en_i: select victim in set miss_pc index.
    - Victim = lowest-index invalid way; else the way with age = 2**WAY_W-1.
    - Write data/tag (from miss_pc), set valid, make victim MRU.
  - Next cycle: if_en_o=1, if_ins_o=mc_ins_i, busy_o=0; return to IDLE.
  - Miss latency = MC latency + 1.
  - mc_en_i received in IDLE is ignored.
- flush_i (while en=1), priority over all other events in that cycle:
  - All valid cleared; ages reset; counters cleared; FSM goes to IDLE.
  - No if_en_o for a request or fill arriving in the flush cycle.
  - A fill for the cancelled miss arriving later is dropped, since the FSM is in IDLE.
- Simultaneous mc_en_i and if_en_i in WAIT: fill processed; the new request is ignored.
- Counters wrap modulo 2**CNT_W.
- en=0: all registers hold, including FSM and counters; pulse outputs drive 0. A pulse input arriving while en=0 is lost; IF/MC re-issue.
- WAY_W=0: direct-mapped; age logic degenerates; always replace way 0.
- Ages stay a permutation of 0..ways-1 within each set at all times.

Test Plan:
- Cold miss: rst, then if_pc_i=0x0010 → mc_en_o=1, mc_pc_o=0x0010 one cycle later; busy_o=1. mc_ins_i=0x00500093 → next cycle if_en_o=1, if_ins_o=0x00500093; miss_cnt=1.
- Hit: refetch 0x0010 → if_en_o=1 exactly 1 cycle later, same data; no mc_en_o; hit_cnt=1.
- LRU eviction (defaults, 4 sets/2 ways):
  - Fill 0x0000, 0x0010, 0x0020 (all index 0); 0x0020 evicts 0x0000.
  - Refetch 0x0010 → hit; refetch 0x0000 → miss.
  - Touch 0x0010, then miss 0x0030 → evicts 0x0020 (then 0x0020 misses).
- Miss-PC latching: miss at 0x0004; change if_pc_i to 0x0008 during WAIT (if_en_i=0); fill 0xDEADBEEF → fetch 0x0004 hits with 0xDEADBEEF; 0x0008 misses.
- Flush mid-miss: miss at 0x0040, flush_i for 1 cycle, then mc_en_i → no if_en_o; busy_o=0; counters=0; 0x0040 misses again.
- en gating and WAY_W=2: with en=0, pulse if_en_i → no outputs, state unchanged. WAY_W=2: five distinct tags in set 1 → first-filled tag evicted; other four hit.
